bru_pred: RTL and testbench

- Parametrised branch resolution unit with branch prediction; successor to the combinational branch unit.
- Resolves all six RISC-V conditional branches plus JAL/JALR using its own comparator, with no external ALU flag.
- Holds a 2-bit saturating-counter branch history table (BHT) that fetch reads combinationally.
- Registers each resolved result and raises a redirect on misprediction. Sits between issue and the fetch PC mux.

---
 rtl/bru_pred.sv | 159 +++++++++++++++
 tb/tb_bru_pred.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bru_pred.sv
// Branch resolution unit with a 2-bit saturating-counter BHT.
// Optional BRU_STATS_EN adds branch/mispredict counters.
module bru_pred #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int PC_STEP   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_branch,
    input  logic            is_jump,
    input  logic [2:0]      bru_op,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    input  logic [XLEN-1:0] lk_pc,
    output logic            lk_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            is_taken,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] link_data,
    output logic            illegal
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic            eq, lt, ltu, cond;
    logic            ill_c, tk_c, rd_c, acc;
    logic [XLEN-1:0] tgt_c, seq_c, npc_c;
    logic [IDX_W-1:0] upd_idx, lk_idx;
    logic [1:0]      cnt_cur, cnt_nxt;

    logic            vld_q, vld_d;
    logic            tk_q, rd_q, ill_q;
    logic [XLEN-1:0] rpc_q, link_q;
    logic [1:0]      bht_q [BHT_DEPTH];

    assign eq  = rs1_data == rs2_data;
    assign lt  = $signed(rs1_data) < $signed(rs2_data);
    assign ltu = rs1_data < rs2_data;

    always_comb begin
        cond = 1'b0;
        unique case (bru_op)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b100:  cond = lt;
            3'b101:  cond = !lt;
            3'b110:  cond = ltu;
            3'b111:  cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

    assign ill_c = is_branch && (bru_op[2:1] == 2'b01);
    assign tk_c  = is_jump || (is_branch && cond);
    assign seq_c = pc + XLEN'(PC_STEP);

    always_comb begin
        tgt_c = pc + imm;
        if (is_jump && bru_op[0]) begin
            tgt_c = (rs1_data + imm) & ~XLEN'(1);
        end
    end

    assign npc_c = tk_c ? tgt_c : seq_c;
    assign rd_c  = (is_branch || is_jump) &&
                   ((tk_c != pred_taken) ||
                    (tk_c && (tgt_c != pred_target)));

    assign in_ready = !flush && (!out_valid || out_ready);
    assign acc      = in_valid && in_ready;

    always_comb begin
        vld_d = vld_q;
        if (flush)          vld_d = 1'b0;
        else if (acc)       vld_d = 1'b1;
        else if (out_ready) vld_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            tk_q   <= 1'b0;
            rd_q   <= 1'b0;
            rpc_q  <= '0;
            link_q <= '0;
            ill_q  <= 1'b0;
        end else begin
            vld_q <= vld_d;
            if (acc) begin
                tk_q   <= tk_c;
                rd_q   <= rd_c;
                rpc_q  <= rd_c ? npc_c : '0;
                link_q <= seq_c;
                ill_q  <= ill_c;
            end
        end
    end

    assign upd_idx = pc[IDX_W+1:2];
    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign cnt_cur = bht_q[upd_idx];

    always_comb begin
        cnt_nxt = cnt_cur;
        if (tk_c) begin
            if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'b01;
        end else begin
            if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'b01;
        end
    end

    // Lookup reads the stored value; a same-cycle update is not bypassed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
        end else if (acc && is_branch && !ill_c) begin
            bht_q[upd_idx] <= cnt_nxt;
        end
    end

    assign lk_taken    = bht_q[lk_idx][1];
    assign out_valid   = vld_q;
    assign is_taken    = tk_q;
    assign redirect    = rd_q;
    assign redirect_pc = rpc_q;
    assign link_data   = link_q;
    assign illegal     = ill_q;

`ifdef BRU_STATS_EN
    logic [31:0] nbr_q, nmp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nbr_q <= '0;
            nmp_q <= '0;
        end else if (acc) begin
            if (is_branch) nbr_q <= nbr_q + 32'd1;
            if (rd_c)      nmp_q <= nmp_q + 32'd1;
        end
    end

    assign stat_branches = nbr_q;
    assign stat_mispred  = nmp_q;
`endif
endmodule

// File: tb/tb_bru_pred.sv
// Directed bench for bru_pred: vector table plus handshake,
// saturation, flush and reset sequences.
module tb_bru_pred;
    logic        clk, rst_n, flush, in_valid, in_ready;
    logic        is_branch, is_jump;
    logic [2:0]  bru_op;
    logic [31:0] pc, rs1_data, rs2_data, imm, pred_target, lk_pc;
    logic        pred_taken, lk_taken, out_valid, out_ready;
    logic        is_taken, redirect, illegal;
    logic [31:0] redirect_pc, link_data;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    int errors = 0;
    int checks = 0;

    bru_pred dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .is_branch(is_branch), .is_jump(is_jump),
        .bru_op(bru_op), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .pred_taken(pred_taken),
        .pred_target(pred_target), .lk_pc(lk_pc),
        .lk_taken(lk_taken), .out_valid(out_valid),
        .out_ready(out_ready), .is_taken(is_taken),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .link_data(link_data), .illegal(illegal)
`ifdef BRU_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispred(stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        br, jp;
        logic [2:0]  op;
        logic [31:0] pc, a, b, imm;
        logic        pt;
        logic [31:0] ptg, lk;
        logic        e_tk, e_rd;
        logic [31:0] e_rpc, e_link;
        logic        e_ill, e_lk;
    } vec_t;

    vec_t v[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic br, input logic jp,
                         input logic [2:0] op, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic pt,
                         input logic [31:0] ptg);
        in_valid = 1'b1; is_branch = br; is_jump = jp;
        bru_op = op; pc = p; rs1_data = a; rs2_data = b;
        imm = im; pred_taken = pt; pred_target = ptg;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        is_branch = 1'b0; is_jump = 1'b0; bru_op = 3'b0;
        pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;
        pred_taken = 1'b0; pred_target = '0; lk_pc = 32'h40;
        out_ready = 1'b1;

        v[0]  = '{1,0,3'b000,32'h40,5,5,32'h20,0,0,32'h40,
                  1,1,32'h60,32'h44,0,1};
        v[1]  = '{1,0,3'b100,32'h10,32'hFFFFFFFF,1,32'h10,1,32'h20,
                  32'h10,1,0,0,32'h14,0,1};
        v[2]  = '{1,0,3'b110,32'h14,32'hFFFFFFFF,1,32'h10,1,32'h24,
                  32'h14,0,1,32'h18,32'h18,0,0};
        v[3]  = '{1,0,3'b111,32'h18,0,0,32'hFFFFFFF8,0,0,
                  32'h18,1,1,32'h10,32'h1C,0,1};
        v[4]  = '{1,0,3'b001,32'h20,3,3,32'h40,0,0,
                  32'h20,0,0,0,32'h24,0,0};
        v[5]  = '{1,0,3'b101,32'h24,1,32'hFFFFFFFF,8,0,0,
                  32'h24,1,1,32'h2C,32'h28,0,1};
        v[6]  = '{0,1,3'b001,32'h100,32'h203,0,0,1,32'h202,
                  32'h40,1,0,0,32'h104,0,1};
        v[7]  = '{0,1,3'b001,32'h100,32'h203,0,0,1,32'h200,
                  32'h14,1,1,32'h202,32'h104,0,0};
        v[8]  = '{0,1,3'b000,32'hFFFFFFF0,0,0,32'h20,1,32'h10,
                  32'h18,1,0,0,32'hFFFFFFF4,0,1};
        v[9]  = '{1,0,3'b010,32'h10,1,1,32'h100,1,32'h110,
                  32'h10,0,1,32'h14,32'h14,1,1};
        v[10] = '{0,0,3'b000,32'h300,0,0,32'h8,1,32'h308,
                  32'h300,0,0,0,32'h304,0,0};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_is_taken", is_taken, 0);
        chk("rst_redirect", redirect, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_link", link_data, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_lk_taken", lk_taken, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(v[i].br, v[i].jp, v[i].op, v[i].pc, v[i].a,
                  v[i].b, v[i].imm, v[i].pt, v[i].ptg);
            lk_pc = v[i].lk;
            if (i == 0) chk("lk_pre_update", lk_taken, 0);
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            step();
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_taken", i), is_taken, v[i].e_tk);
            chk($sformatf("v%0d_redir", i), redirect, v[i].e_rd);
            chk($sformatf("v%0d_rpc", i), redirect_pc, v[i].e_rpc);
            chk($sformatf("v%0d_link", i), link_data, v[i].e_link);
            chk($sformatf("v%0d_ill", i), illegal, v[i].e_ill);
            chk($sformatf("v%0d_lk", i), lk_taken, v[i].e_lk);
        end

        @(negedge clk);
        in_valid = 1'b0;
        step();
        chk("drain_valid", out_valid, 0);

        // Backpressure: A held while B waits
        @(negedge clk);
        out_ready = 1'b0;
        drive(1, 0, 3'b000, 32'h400, 7, 7, 32'h10, 0, 0);
        step();
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_rpc", redirect_pc, 32'h410);
        @(negedge clk);
        drive(0, 1, 3'b000, 32'h500, 0, 0, 32'h8, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_stall%0d_ready", k), in_ready, 0);
            chk($sformatf("bp_stall%0d_rpc", k), redirect_pc, 32'h410);
            chk($sformatf("bp_stall%0d_link", k), link_data, 32'h404);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        chk("bp_b_valid", out_valid, 1);
        chk("bp_b_rpc", redirect_pc, 32'h508);
        chk("bp_b_link", link_data, 32'h504);
        @(negedge clk);
        in_valid = 1'b0;
        step();
        chk("bp_no_dup", out_valid, 0);

        // Saturation at pc 0x80, back-to-back
        lk_pc = 32'h80;
        @(negedge clk);
        drive(1, 0, 3'b000, 32'h80, 1, 1, 32'h40, 1, 32'hC0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("sat%0d_valid", k), out_valid, 1);
            chk($sformatf("sat%0d_redir", k), redirect, 0);
        end
        @(negedge clk);
        drive(1, 0, 3'b001, 32'h80, 1, 1, 32'h40, 0, 0);
        step();
        chk("sat_nt1_lk", lk_taken, 1);
        step();
        chk("sat_nt2_lk", lk_taken, 0);

        // Flush: taken branch at 0x80 must not train the BHT
        @(negedge clk);
        drive(1, 0, 3'b000, 32'h80, 1, 1, 32'h40, 1, 32'hC0);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        step();
        chk("flush_valid", out_valid, 0);
        chk("flush_lk", lk_taken, 0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;

        // Reset mid-operation
        @(negedge clk);
        drive(1, 0, 3'b000, 32'h40, 2, 2, 32'h20, 0, 0);
        lk_pc = 32'h40;
        step();
        chk("mid_valid_pre", out_valid, 1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_rpc", redirect_pc, 0);
        chk("mid_rst_lk", lk_taken, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BRU_STATS_EN
        chk("stat_br_rst", stat_branches, 0);
        chk("stat_mp_rst", stat_mispred, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 3)
                drive(1, 0, 3'b000, 32'h600, 1, 1, 32'h10, 0, 0);
            else
                drive(1, 0, 3'b000, 32'h600, 1, 1, 32'h10, 1, 32'h610);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("stat_branches", stat_branches, 10);
        chk("stat_mispred", stat_mispred, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
